// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: handshake bundle for the pipelined immediate extender.
// Input side carries the raw immediate and its extension mode, and the
// output side carries the extended value with the mode alongside it.
// The master modport is the producer/consumer pair around the block.
// The slave modport is the extender itself.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_mode
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_mode
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined immediate extender for the MIPS datapath.
// Modes: 00 sign, 01 zero, 10 LUI (immediate in the top bits), 11 branch
// offset (sign-extend then shift left by 2). The extension is done on the
// input side, then the result walks through STAGES register slots with a
// valid/ready handshake, compressing into empty slots under back-pressure.
// The flush input clears every in-flight entry on the next edge.
// Optional macro IMM_EXT_CNT_EN adds a 16-bit wrapping count of output
// transfers on port xfer_cnt. The count is not cleared by flush.
// Parameter constraints: OUT_W >= IN_W+2, STAGES in 1..4.
module imm_extend_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
`ifdef IMM_EXT_CNT_EN
  output logic [15:0] xfer_cnt,
`endif
  imm_extend_pipe_if.slave bus
);

  localparam int EXT_W = OUT_W - IN_W;

  // Extension of one immediate according to its mode. The branch case
  // drops the top two sign copies, which is lossless because OUT_W >= IN_W+2.
  function automatic logic signed [OUT_W-1:0] f_extend(
    input logic [IN_W-1:0] d,
    input logic [1:0]      m
  );
    logic signed [OUT_W-1:0] v_sx;
    v_sx = {{EXT_W{d[IN_W-1]}}, d};
    case (m)
      2'b00:   f_extend = v_sx;
      2'b01:   f_extend = {{EXT_W{1'b0}}, d};
      2'b10:   f_extend = {d, {EXT_W{1'b0}}};
      default: f_extend = {v_sx[OUT_W-3:0], 2'b00};
    endcase
  endfunction

  // Pipeline state: index 0 is the entry slot, STAGES-1 drives the outputs.
  logic                    r_rdy_en;
  logic [STAGES-1:0]       r_vld;
  logic signed [OUT_W-1:0] r_data [STAGES];
  logic [1:0]              r_mode [STAGES];

  logic [STAGES-1:0]       w_load;
  logic                    w_chain;
  logic                    w_in_xfer;
  logic signed [OUT_W-1:0] w_ext_p0;

  // Ready chain from the output back to the input: a slot may load when it
  // is empty or when everything downstream of it can move this cycle.
  always_comb begin
    w_load  = '0;
    w_chain = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_chain   = !r_vld[k] || w_chain;
      w_load[k] = w_chain;
    end
  end

  // in_ready stays low until the first edge after reset. During flush it is
  // forced high so the producer is never stalled on an entry that will be dropped.
  assign bus.in_ready = r_rdy_en && (flush || w_load[0]);
  assign w_in_xfer    = bus.in_valid && bus.in_ready && !flush;
  assign w_ext_p0     = f_extend(bus.in_data, bus.in_mode);

  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.out_data  = r_data[STAGES-1];
  assign bus.out_mode  = r_mode[STAGES-1];

  // Valid bits and the post-reset ready enable. Flush wins over any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_en <= 1'b0;
      r_vld    <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (flush) begin
        r_vld <= '0;
      end else begin
        if (w_load[0]) r_vld[0] <= w_in_xfer;
        for (int k = 1; k < STAGES; k++) begin
          if (w_load[k]) r_vld[k] <= r_vld[k-1];
        end
      end
    end
  end

  // ---- stage boundary: input -> slot 0 -> ... -> slot STAGES-1 ----
  // Data and mode follow the valid bits. Values in empty slots are don't-care
  // because out_valid masks them. The reset clears them so the outputs read
  // zero while rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
        r_mode[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_data[0] <= w_ext_p0;
        r_mode[0] <= bus.in_mode;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_data[k] <= r_data[k-1];
          r_mode[k] <= r_mode[k-1];
        end
      end
    end
  end

`ifdef IMM_EXT_CNT_EN
  logic        w_out_xfer;
  logic [15:0] r_xfer_cnt;

  assign w_out_xfer = r_vld[STAGES-1] && bus.out_ready;
  assign xfer_cnt   = r_xfer_cnt;

  // Count delivered outputs, including one handed over in a flush cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (w_out_xfer) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed bench for imm_extend_pipe with four instances
// (STAGES = 1, 2, 3, 4) sharing clock and reset. The counter section is
// compiled only when IMM_EXT_CNT_EN is defined.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush1 = 1'b0;
  logic flush4 = 1'b0;
  logic zero_flush = 1'b0;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) b1 ();
  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) b2 ();
  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) b3 ();
  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) b4 ();

`ifdef IMM_EXT_CNT_EN
  logic [15:0] cnt1, cnt2, cnt3, cnt4;
`endif

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush1),
`ifdef IMM_EXT_CNT_EN
    .xfer_cnt(cnt1),
`endif
    .bus(b1)
  );
  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .flush(zero_flush),
`ifdef IMM_EXT_CNT_EN
    .xfer_cnt(cnt2),
`endif
    .bus(b2)
  );
  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(3)) u3 (
    .clk(clk), .rst(rst), .flush(zero_flush),
`ifdef IMM_EXT_CNT_EN
    .xfer_cnt(cnt3),
`endif
    .bus(b3)
  );
  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush4),
`ifdef IMM_EXT_CNT_EN
    .xfer_cnt(cnt4),
`endif
    .bus(b4)
  );

  int checks = 0;
  int errors = 0;
  int sent, rcv, cyc;
  logic rdy, ov;
  logic [31:0] od;
  logic [31:0] exp_m [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.in_valid = 0; b1.in_data = '0; b1.in_mode = '0; b1.out_ready = 1;
    b2.in_valid = 0; b2.in_data = '0; b2.in_mode = '0; b2.out_ready = 1;
    b3.in_valid = 0; b3.in_data = '0; b3.in_mode = '0; b3.out_ready = 1;
    b4.in_valid = 0; b4.in_data = '0; b4.in_mode = '0; b4.out_ready = 1;
    exp_m = '{32'hFFFFF00F, 32'h0000F00F, 32'hF00F0000, 32'hFFFFC03C};

    // Asynchronous reset asserted between clock edges
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
    chk("rst_out_data",  b1.out_data, 32'd0);
    chk("rst_out_mode",  32'(b1.out_mode), 32'd0);
    chk("rst_in_ready",  32'(b1.in_ready), 32'd0);
    tick;
    chk("rst_hold_valid", 32'(b4.out_valid), 32'd0);
    chk("rst_hold_ready", 32'(b4.in_ready), 32'd0);
    #4 rst = 1'b0;
    tick;
    chk("post_rst_ready", 32'(b1.in_ready), 32'd1);

    // Sign extension, STAGES=1
    b1.in_valid = 1; b1.in_data = 16'h8001; b1.in_mode = 2'b00;
    tick;
    chk("sign_valid", 32'(b1.out_valid), 32'd1);
    chk("sign_data",  b1.out_data, 32'hFFFF8001);

    // All four modes on 0xF00F
    for (int m = 0; m < 4; m++) begin
      b1.in_data = 16'hF00F; b1.in_mode = 2'(m);
      tick;
      chk("mode_data", b1.out_data, exp_m[m]);
      chk("mode_tag",  32'(b1.out_mode), 32'(m));
    end
    b1.in_valid = 0;
    tick;
    chk("mode_idle", 32'(b1.out_valid), 32'd0);

    // Back-pressure, STAGES=3: five stalled cycles
    b3.out_ready = 0; sent = 0;
    for (int k = 0; k < 5; k++) begin
      b3.in_valid = 1; b3.in_data = 16'(sent + 1); b3.in_mode = 2'b01;
      #1;
      rdy = b3.in_ready;
      chk("bp_in_ready",  32'(rdy), 32'(k < 3));
      chk("bp_out_valid", 32'(b3.out_valid), 32'(k >= 3));
      if (k >= 3) chk("bp_hold", b3.out_data, 32'h00000001);
      @(posedge clk);
      if (rdy) sent++;
      #1;
    end
    b3.out_ready = 1; rcv = 0; cyc = 0;
    while (rcv < 8 && cyc < 40) begin
      b3.in_valid = (sent < 8); b3.in_data = 16'(sent + 1);
      #1;
      rdy = b3.in_ready; ov = b3.out_valid; od = b3.out_data;
      chk("bp_no_gap", 32'(ov), 32'd1);
      if (ov) chk("bp_order", od, 32'(rcv + 1));
      if (ov) chk("bp_mode", 32'(b3.out_mode), 32'd1);
      @(posedge clk);
      if (rdy && b3.in_valid) sent++;
      if (ov) rcv++;
      #1;
      cyc++;
    end
    b3.in_valid = 0;
    chk("bp_count", 32'(rcv), 32'd8);
    chk("bp_drained", 32'(b3.out_valid), 32'd0);

    // Full throughput, STAGES=2
    for (int c = 0; c < 22; c++) begin
      b2.in_valid = (c < 20); b2.in_data = 16'(16'h0100 + c); b2.in_mode = 2'b00;
      #1;
      if (c < 20) chk("tp_in_ready", 32'(b2.in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("tp_out_valid", 32'(b2.out_valid), 32'(c >= 1 && c <= 20));
      if (c >= 1 && c <= 20) chk("tp_data", b2.out_data, 32'(32'h100 + c - 1));
    end
    b2.in_valid = 0;

    // Flush, STAGES=4: fill all four slots, then flush with 0x1234 presented
    b4.out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      b4.in_valid = 1; b4.in_data = 16'(16'h0A01 + k); b4.in_mode = 2'b00;
      #1;
      chk("fl_load_ready", 32'(b4.in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    b4.in_data = 16'h1234; flush4 = 1;
    #1;
    chk("fl_ready_in_flush", 32'(b4.in_ready), 32'd1);
    chk("fl_valid_before", 32'(b4.out_valid), 32'd1);
    chk("fl_data_before", b4.out_data, 32'h00000A01);
    @(posedge clk);
    #1;
    flush4 = 0; b4.in_valid = 0; b4.out_ready = 1;
    chk("fl_valid_after", 32'(b4.out_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("fl_no_1234", 32'(b4.out_valid), 32'd0);
    end
    b4.in_valid = 1; b4.in_data = 16'h0055; b4.in_mode = 2'b01;
    #1;
    chk("fl_new_ready", 32'(b4.in_ready), 32'd1);
    @(posedge clk);
    #1;
    b4.in_valid = 0;
    for (int d = 1; d <= 4; d++) begin
      chk("fl_latency", 32'(b4.out_valid), 32'(d == 4));
      if (d == 4) chk("fl_new_data", b4.out_data, 32'h00000055);
      if (d < 4) tick;
    end
    tick;
    chk("fl_consumed", 32'(b4.out_valid), 32'd0);

`ifdef IMM_EXT_CNT_EN
    // Transfer counter
    chk("cnt_u1", 32'(cnt1), 32'd5);
    chk("cnt_u2", 32'(cnt2), 32'd20);
    chk("cnt_u3", 32'(cnt3), 32'd8);
    chk("cnt_u4", 32'(cnt4), 32'd1);
    rst = 1'b1;
    #1;
    chk("cnt_reset", 32'(cnt1), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick;
    sent = 0; rcv = 0; cyc = 0;
    b1.out_ready = 1; b1.in_mode = 2'b00;
    while (rcv < 65537 && cyc < 70000) begin
      b1.in_valid = (sent < 65537); b1.in_data = 16'(sent);
      #1;
      rdy = b1.in_ready; ov = b1.out_valid;
      @(posedge clk);
      if (rdy && b1.in_valid) sent++;
      if (ov) rcv++;
      #1;
      cyc++;
    end
    b1.in_valid = 0;
    chk("cnt_transfers", 32'(rcv), 32'd65537);
    chk("cnt_wrap", 32'(cnt1), 32'h0001);
    b1.in_valid = 1; b1.in_data = 16'h1234; flush1 = 1;
    @(posedge clk);
    #1;
    flush1 = 0; b1.in_valid = 0;
    chk("cnt_flush_keep", 32'(cnt1), 32'h0001);
    chk("cnt_flush_drop", 32'(b1.out_valid), 32'd0);
    b1.in_valid = 1; b1.in_data = 16'h0002;
    tick;
    b1.in_valid = 0; flush1 = 1;
    #1;
    chk("cnt_hs_valid", 32'(b1.out_valid), 32'd1);
    @(posedge clk);
    #1;
    flush1 = 0;
    chk("cnt_flush_hs", 32'(cnt1), 32'h0002);
    chk("cnt_flush_hs_valid", 32'(b1.out_valid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender for the MIPS datapath; next generation of the single-register 16-to-32 sign extender.
- Adds selectable extension modes (sign, zero, LUI, branch offset), configurable width and pipeline depth, a valid/ready handshake with back-pressure, and a synchronous flush.
- Sits between instruction decode and the ALU operand mux or branch adder.

Parameters:
- IN_W, 16, immediate input width in bits.
- OUT_W, 32, extended output width in bits; must satisfy OUT_W >= IN_W+2.
- STAGES, 1, number of register stages, 1..4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all in-flight entries.
- in_valid  input  1  input entry is valid.
- in_ready  output  1  block can accept an entry this cycle.
- in_data  input  IN_W  raw immediate.
- in_mode  input  2  extension mode for this entry.
- out_valid  output  1  output entry is valid.
- out_ready  input  1  downstream accepts the entry.
- out_data  output  OUT_W  extended result.
- out_mode  output  2  mode carried alongside out_data.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst.
- While rst=1, regardless of clk:
  - every stage valid bit is 0, so out_valid=0;
  - out_data=0 and out_mode=0;
  - in_ready=0.
- The cycle after rst deasserts: in_ready=1.
- Reset mid-operation drops all entries with no partial output.
- Mode encoding, computed combinationally on in_data before stage 1:
  - 00 SIGN: upper OUT_W-IN_W bits replicate in_data[IN_W-1].
  - 01 ZERO: upper bits are 0.
  - 10 LUI: in_data sits in bits [OUT_W-1:OUT_W-IN_W]; lower bits are 0.
  - 11 BRANCH: sign-extend, then shift left by 2; bits [1:0] are 0 and bits above the extended value carry the sign. No overflow is possible because OUT_W >= IN_W+2.
- Pipeline:
  - STAGES register slots, each holding valid, data and mode.
  - Stage k loads from stage k-1 when stage k is empty or stage k is advancing.
  - The last stage advances when out_valid && out_ready.
  - in_ready = !valid[1] || advance[1], i.e. a combinational ready chain from out_ready; this gives full throughput.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: an accepted entry appears on out_* exactly STAGES cycles later when there is no back-pressure.
- Stall hold: while out_valid=1 and out_ready=0, out_data and out_mode hold stable. Entries compress into empty upstream slots; once all STAGES slots are full, in_ready=0.
- Ordering: strict FIFO order; no duplication and no loss.
- Flush:
  - On a clock edge with flush=1, all valid bits clear.
  - Data registers may keep stale values but are masked by out_valid=0.
  - An input presented in the flush cycle is dropped, and in_ready=1 in the flush cycle.
  - Flush takes priority over any transfer. An output handshake in the same cycle still counts as delivered.
- No combinational path from in_* to out_*.

Optional Feature:
- Macro: IMM_EXT_CNT_EN.
- When defined:
  - Extra output port xfer_cnt (output, 16 bits): count of output transfers, wrapping 0xFFFF to 0x0000.
  - Reset value 0; flush does not clear it.
  - Increments on the same edge the output transfer completes.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset and sign extension:
  - Stimulus: STAGES=1; assert rst asynchronously mid-cycle, then release; send in_data=16'h8001, mode 00, out_ready=1.
  - Required: during reset out_valid=0, out_data=0, in_ready=0; one cycle later out_data=32'hFFFF8001.
- All modes:
  - Stimulus: in_data=16'hF00F with modes 00, 01, 10, 11.
  - Required outputs: 32'hFFFFF00F, 32'h0000F00F, 32'hF00F0000, 32'hFFFFC03C; out_mode matches each entry.
- Back-pressure:
  - Stimulus: STAGES=3; stream 0x0001..0x0008 in mode 01; hold out_ready=0 for 5 cycles.
  - Required: in_ready=0 once 3 entries are held; out_data stays at 0x00000001 throughout the stall.
  - Then release out_ready: all 8 values emerge in order with no gaps or duplicates.
- Full throughput:
  - Stimulus: STAGES=2; in_valid=1 and out_ready=1 for 20 cycles.
  - Required: one output per cycle after 2 cycles of latency.
- Flush:
  - Stimulus: STAGES=4; load 4 entries; assert flush for one cycle while in_valid=1 with 0x1234.
  - Required: out_valid=0 on the next cycle; 0x1234 never appears; the next accepted entry emerges 4 cycles after acceptance.
- Counter (IMM_EXT_CNT_EN defined):
  - Stimulus: preload the count near wrap by running 65537 transfers.
  - Required: xfer_cnt=0x0001; a flush mid-stream leaves xfer_cnt unchanged.
